tx_ep_arb: RTL and testbench
============================

# tx_ep_arb

Round-robin arbiter and TX multiplexer for the shared PCIe endpoint transmit (TRN tx) interface. Up to NREQ TLP sources (host-memory reader, packet writer, register completer) raise `req_ep`. The arbiter grants exactly one source at a time via `my_trn`, tracks its ownership through `drv_ep`, and steers that source's TRN tx signals onto the core. It closes the `req_ep`/`my_trn`/`drv_ep` handshake that every TX-side master in the design already implements.

## Interface
- NREQ, 3, number of requesters (2..8)
- MAX_WAIT, 64, cycles a grantee may hold a grant without asserting `drv_ep` before revocation
- WAITW, 7, width of wait counter (≥ clog2(MAX_WAIT)+1)
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- req_ep  in  NREQ  per-requester request
- drv_ep  in  NREQ  per-requester "driving the endpoint"
- my_trn  out  NREQ  per-requester grant, registered, one-hot or zero
- req_td  in  NREQ*64  requester TD, slice i = [64i+63:64i]
- req_trem_n  in  NREQ*8  requester REM
- req_tsof_n, req_teof_n, req_tsrc_rdy_n  in  NREQ each  requester framing
- trn_td  out  64  to core
- trn_trem_n  out  8  to core
- trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n  out  1 each  to core
- arb_err  out  1  sticky protocol-violation flag
- `trn_tdst_rdy_n` and `trn_tbuf_av` go from the core straight to all requesters. They are not routed through this block.

## Operation
- State machine: IDLE, GRANT, DRIVE, RELEASE. Registers: `gnt_idx`, round-robin pointer `rr_ptr`, `wait_cnt`.
- IDLE:
  - `my_trn`=0.
  - If any `req_ep`, the winner is the first set bit searching upward from `rr_ptr` with wrap.
  - `gnt_idx`<=winner, `my_trn[winner]`<=1, `wait_cnt`<=0, state -> GRANT.
- GRANT, in priority order:
  - `drv_ep[g]` -> DRIVE.
  - else `!req_ep[g]` (withdrawn) -> RELEASE.
  - else `wait_cnt`==MAX_WAIT-1 -> RELEASE (revoke).
  - else `wait_cnt`++.
- DRIVE: `my_trn[g]` held 1. When `drv_ep[g]` falls -> IDLE, `my_trn`<=0, `rr_ptr`<=(g+1) mod NREQ.
- RELEASE (exactly one cycle):
  - `my_trn`=0.
  - Catches the race where the requester accepted the grant in the same cycle it was revoked.
  - If `drv_ep[g]` -> DRIVE with `my_trn[g]`<=1. Else -> IDLE, `rr_ptr`<=(g+1) mod NREQ.
- Mux:
  - Combinational. Selects requester g when state ∈ {GRANT, DRIVE, RELEASE} and `drv_ep[g]`=1.
  - Otherwise outputs idle values: td=0, trem_n=8'hFF, tsof_n=teof_n=tsrc_rdy_n=1.
  - No register on the data path. Requesters sample `trn_tdst_rdy_n` directly, so adding latency would break the handshake.
- `arb_err`:
  - Set when `drv_ep[i]`=1 for any i≠g, or any `drv_ep` is set in IDLE.
  - Cleared only by reset.
  - The offending requester is never muxed.

## Timing
- Reset (async assert, sync release): state IDLE, `my_trn`=0, `gnt_idx`=0, `rr_ptr`=0, `wait_cnt`=0, `arb_err`=0. Mux outputs hold idle values.
- `req_ep` sampled at edge t -> `my_trn` high after edge t. Grant latency is 1 cycle.
- `drv_ep` fall sampled at edge t -> `my_trn` low after t. The earliest next grant is after edge t+1, giving at least one idle cycle between owners.
- Simultaneous requests: pure round-robin from `rr_ptr`. The last owner has lowest priority next round.
- A requester re-raising `req_ep` immediately after its release waits behind any other pending requester.
- Reset mid-packet: outputs return to idle values immediately (async). The core's TLP is truncated; recovery is the system-level reset's responsibility.
- MAX_WAIT counts from the first GRANT cycle. Revocation happens after exactly MAX_WAIT GRANT cycles.

## Structure
- Shared package/include holds:
  - state encodings (one-hot, 4 bits)
  - TRN idle constants (TD_IDLE=0, TREM_IDLE=8'hFF)
  - defaults for NREQ and MAX_WAIT
- One combinational sub-module, `ep_rr_pick`: inputs request vector and pointer; outputs winner index and valid. It is instantiated once.
- The FSM, counter and mux live in `tx_ep_arb`.

## Test plan
- **Single request:** req_ep[1]=1 at cycle 0 -> my_trn=3'b010 at cycle 1. Requester drives a 3-QW TLP with drv_ep, and trn_* mirrors req_*[1] bit-exactly. When drv_ep drops, my_trn=0 next cycle and rr_ptr=2.
- **Contention:** req_ep=3'b111 held, each requester drives a 2-cycle TLP -> grant order 0,1,2,0 with one idle cycle between owners.
- **Stall revoke:** with MAX_WAIT=8, req_ep[0]=1 and drv_ep never asserted -> my_trn[0] drops after 8 GRANT cycles, then req_ep[2] is granted.
- **Revoke race:** requester asserts drv_ep[0] in the RELEASE cycle -> my_trn[0] re-asserted next cycle, state DRIVE, TLP forwarded intact, arb_err=0.
- **Violation:** drv_ep[2]=1 while g=0 -> arb_err=1 the next cycle, and req_*[2] never appears on trn_*.
- **Reset mid-packet:** rst_n low during DRIVE -> trn_tsrc_rdy_n=1, trem_n=8'hFF, my_trn=0 without a clock edge. After release, the first request is granted normally.

Source files
------------

// File: rtl/tx_ep_arb_pkg.sv
// tx_ep_arb_pkg: shared state encoding, TRN idle values and parameter defaults for the tx arbiter
package tx_ep_arb_pkg;
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    GRANT   = 4'b0010,
    DRIVE   = 4'b0100,
    RELEASE = 4'b1000
  } state_t;
  localparam logic [63:0] TD_IDLE = 64'h0;
  localparam logic [7:0] TREM_IDLE = 8'hFF;
  localparam int NREQ_DEF = 3;
  localparam int MAX_WAIT_DEF = 64;
  localparam int WAITW_DEF = 7;
endpackage

// File: rtl/ep_rr_pick.sv
// ep_rr_pick: combinational round-robin picker, first set request searching upward from ptr with wrap
//   req   in   request vector
//   ptr   in   highest-priority index
//   idx   out  winning index (0 when nothing requests)
//   valid out  any request present
module ep_rr_pick import tx_ep_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            valid
);
  logic [IW-1:0] j;
  // Scan from the farthest offset down so the offset closest to ptr wins.
  always_comb begin
    idx = '0;
    j = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NREQ);
      if (req[j]) idx = j;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/tx_ep_arb.sv
// tx_ep_arb: round-robin arbiter and TRN tx multiplexer for the shared PCIe endpoint transmit port
//   clk, rst_n                       clock, async active-low reset
//   req_ep / drv_ep                  per-requester request / driving-the-endpoint
//   my_trn                           registered one-hot grant
//   req_td, req_trem_n, req_t*_n     per-requester TRN tx signals (slice i per requester)
//   trn_td, trn_trem_n, trn_t*_n     muxed TRN tx signals to the core
//   arb_err                          sticky protocol-violation flag
module tx_ep_arb import tx_ep_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int WAITW = WAITW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_ep,
  input  logic [NREQ-1:0]   drv_ep,
  output logic [NREQ-1:0]   my_trn,
  input  logic [NREQ*64-1:0] req_td,
  input  logic [NREQ*8-1:0] req_trem_n,
  input  logic [NREQ-1:0]   req_tsof_n,
  input  logic [NREQ-1:0]   req_teof_n,
  input  logic [NREQ-1:0]   req_tsrc_rdy_n,
  output logic [63:0]       trn_td,
  output logic [7:0]        trn_trem_n,
  output logic              trn_tsof_n,
  output logic              trn_teof_n,
  output logic              trn_tsrc_rdy_n,
  output logic              arb_err
);
  localparam int IW = $clog2(NREQ);
  state_t state, state_nxt;
  logic [IW-1:0] gnt_idx, rr_ptr, win, tgt, nxt_ptr;
  logic [WAITW-1:0] wait_cnt;
  logic [NREQ-1:0] my_trn_nxt, gnt_oh;
  logic win_vld, g_drv, g_req, bad, sel;

  ep_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(req_ep),
    .ptr(rr_ptr),
    .idx(win),
    .valid(win_vld)
  );

  assign gnt_oh = NREQ'(1) << gnt_idx;
  assign g_drv = drv_ep[gnt_idx];
  assign g_req = req_ep[gnt_idx];
  assign nxt_ptr = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  // Any non-owner driving, or anyone driving with no owner, is a protocol violation.
  assign bad = (state == IDLE) ? |drv_ep : |(drv_ep & ~gnt_oh);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      my_trn <= '0;
      gnt_idx <= '0;
      rr_ptr <= '0;
      wait_cnt <= '0;
      arb_err <= 1'b0;
    end else begin
      state <= state_nxt;
      my_trn <= my_trn_nxt;
      if (state == IDLE && win_vld) gnt_idx <= win;
      if (state == IDLE) wait_cnt <= '0;
      else if (state == GRANT && state_nxt == GRANT) wait_cnt <= wait_cnt + 1'b1;
      if ((state == DRIVE || state == RELEASE) && state_nxt == IDLE) rr_ptr <= nxt_ptr;
      if (bad) arb_err <= 1'b1;
    end

  // RELEASE gives a revoked requester one cycle to show it took the grant anyway.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:           state_nxt = win_vld ? GRANT : IDLE;
      GRANT:          state_nxt = g_drv ? DRIVE :
                                  (!g_req || wait_cnt == WAITW'(MAX_WAIT - 1)) ? RELEASE : GRANT;
      DRIVE, RELEASE: state_nxt = g_drv ? DRIVE : IDLE;
      default:        state_nxt = IDLE;
    endcase
    tgt = (state == IDLE) ? win : gnt_idx;
    my_trn_nxt = (state_nxt == GRANT || state_nxt == DRIVE) ? NREQ'(1) << tgt : '0;
  end

  // Unregistered data path: requesters see trn_tdst_rdy_n directly.
  always_comb begin
    sel = (state != IDLE) && g_drv;
    trn_td = sel ? req_td[gnt_idx*64 +: 64] : TD_IDLE;
    trn_trem_n = sel ? req_trem_n[gnt_idx*8 +: 8] : TREM_IDLE;
    trn_tsof_n = sel ? req_tsof_n[gnt_idx] : 1'b1;
    trn_teof_n = sel ? req_teof_n[gnt_idx] : 1'b1;
    trn_tsrc_rdy_n = sel ? req_tsrc_rdy_n[gnt_idx] : 1'b1;
  end
endmodule

// File: tb/tb_tx_ep_arb.sv
// tb_tx_ep_arb: scoreboard bench for tx_ep_arb with directed requester scenarios
module tb_tx_ep_arb;
  import tx_ep_arb_pkg::*;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_ep, drv_ep, my_trn, req_tsof_n, req_teof_n, req_tsrc_rdy_n;
  logic [N*64-1:0] req_td;
  logic [N*8-1:0] req_trem_n;
  logic [63:0] trn_td;
  logic [7:0] trn_trem_n;
  logic trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, arb_err;
  logic r_req[N], r_drv[N], r_sof[N], r_eof[N], r_src[N];
  logic [63:0] r_td[N];
  logic [7:0] r_rem[N];
  typedef struct packed {logic [63:0] td; logic [7:0] rem; logic sof; logic eof;} beat_t;
  beat_t exp_beats[$];
  logic [N-1:0] exp_gnt[$];
  beat_t mb, eb;
  logic [N-1:0] prev_trn = '0;
  logic abort = 1'b0;
  int tests = 0, fails = 0, cnt;

  tx_ep_arb #(.NREQ(N), .MAX_WAIT(8), .WAITW(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_ep(req_ep), .drv_ep(drv_ep), .my_trn(my_trn),
    .req_td(req_td), .req_trem_n(req_trem_n), .req_tsof_n(req_tsof_n), .req_teof_n(req_teof_n),
    .req_tsrc_rdy_n(req_tsrc_rdy_n), .trn_td(trn_td), .trn_trem_n(trn_trem_n),
    .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < N; i++) begin
      req_ep[i] = r_req[i];
      drv_ep[i] = r_drv[i];
      req_tsof_n[i] = r_sof[i];
      req_teof_n[i] = r_eof[i];
      req_tsrc_rdy_n[i] = r_src[i];
      req_td[64*i +: 64] = r_td[i];
      req_trem_n[8*i +: 8] = r_rem[i];
    end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_req(input int idx);
    r_drv[idx] = 1'b0;
    r_src[idx] = 1'b1;
    r_sof[idx] = 1'b1;
    r_eof[idx] = 1'b1;
    r_td[idx] = 64'hDEAD_BEEF_0000_0000 | 64'(idx);
    r_rem[idx] = 8'h00;
  endtask

  task automatic wait_trn(input int idx, input logic v);
    int c = 0;
    while (my_trn[idx] !== v && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("wait_trn", 80'(my_trn[idx]), 80'(v));
  endtask

  // Requester model: request, wait for grant (optionally until it is revoked), then drive nb beats.
  task automatic send(input int idx, input int nb, input int seed, input bit late);
    int t = 0;
    r_req[idx] = 1'b1;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!my_trn[idx] && t < 40);
    check("grant_wait", 80'(my_trn[idx]), 80'(1));
    if (!my_trn[idx]) begin
      r_req[idx] = 1'b0;
      return;
    end
    if (late) begin
      t = 0;
      do begin
        @(posedge clk); #1;
        t++;
      end while (my_trn[idx] && t < 40);
    end
    for (int k = 0; k < nb; k++) begin
      if (abort) break;
      r_drv[idx] = 1'b1;
      r_src[idx] = 1'b0;
      r_sof[idx] = (k != 0);
      r_eof[idx] = (k != nb - 1);
      r_td[idx] = {16'hC0DE, 8'(idx), 8'(seed), 32'(k)};
      r_rem[idx] = (k == nb - 1) ? 8'h0F : 8'h00;
      exp_beats.push_back({r_td[idx], r_rem[idx], r_sof[idx], r_eof[idx]});
      @(posedge clk); #1;
    end
    idle_req(idx);
    r_req[idx] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && !trn_tsrc_rdy_n) begin
      mb = {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n};
      if (exp_beats.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL beat_unexpected: got %h, expected no beat", mb);
      end else begin
        eb = exp_beats.pop_front();
        check("beat", 80'(mb), 80'(eb));
      end
    end
    if (rst_n && my_trn != prev_trn && my_trn != '0) begin
      if (exp_gnt.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL grant_unexpected: got %b, expected no grant", my_trn);
      end else check("grant", 80'(my_trn), 80'(exp_gnt.pop_front()));
      check("gnt_gap", 80'(prev_trn), 80'(0));
    end
    prev_trn = my_trn;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      r_req[i] = 1'b0;
      idle_req(i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_my_trn", 80'(my_trn), 80'(0));
    check("rst_arb_err", 80'(arb_err), 80'(0));
    check("rst_td", 80'(trn_td), 80'(0));
    check("rst_trem", 80'(trn_trem_n), 80'(8'hFF));
    check("rst_framing", 80'({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}), 80'(3'b111));
    @(posedge clk); #1;
    rst_n = 1'b1;

    exp_gnt.push_back(3'b010);
    send(1, 3, 1, 0);
    @(posedge clk);
    @(negedge clk);
    check("single_drop", 80'(my_trn), 80'(0));
    check("single_rr_ptr", 80'(dut.rr_ptr), 80'(2));

    exp_gnt.push_back(3'b100);
    send(2, 1, 2, 0);
    @(posedge clk);
    @(negedge clk);
    check("rr_wrap", 80'(dut.rr_ptr), 80'(0));

    exp_gnt.push_back(3'b001);
    exp_gnt.push_back(3'b010);
    exp_gnt.push_back(3'b100);
    exp_gnt.push_back(3'b001);
    fork
      begin
        send(0, 2, 3, 0);
        send(0, 2, 4, 0);
      end
      send(1, 2, 5, 0);
      send(2, 2, 6, 0);
    join
    @(posedge clk);
    @(negedge clk);
    check("contend_rr_ptr", 80'(dut.rr_ptr), 80'(1));

    exp_gnt.push_back(3'b001);
    r_req[0] = 1'b1;
    wait_trn(0, 1'b1);
    r_req[2] = 1'b1;
    cnt = 1;
    while (my_trn[0] && cnt < 40) begin
      @(negedge clk);
      if (my_trn[0]) cnt++;
    end
    check("stall_cycles", 80'(cnt), 80'(8));
    exp_gnt.push_back(3'b100);
    fork
      send(2, 1, 7, 0);
      begin
        repeat (3) @(posedge clk);
        #1 r_req[0] = 1'b0;
      end
    join

    exp_gnt.push_back(3'b001);
    exp_gnt.push_back(3'b001);
    fork
      send(0, 3, 8, 1);
      begin
        wait_trn(0, 1'b1);
        wait_trn(0, 1'b0);
        @(negedge clk);
        check("race_state", 80'(dut.state), 80'(DRIVE));
        check("race_my_trn", 80'(my_trn), 80'(3'b001));
      end
    join
    @(posedge clk);
    @(negedge clk);
    check("race_arb_err", 80'(arb_err), 80'(0));

    exp_gnt.push_back(3'b001);
    fork
      send(0, 4, 9, 0);
      begin
        wait_trn(0, 1'b1);
        @(posedge clk); #1;
        r_drv[2] = 1'b1;
        r_src[2] = 1'b0;
        r_sof[2] = 1'b0;
        r_td[2] = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk); #1;
        idle_req(2);
        @(negedge clk);
        check("viol_arb_err", 80'(arb_err), 80'(1));
      end
    join

    exp_gnt.push_back(3'b010);
    fork
      send(1, 6, 10, 0);
      begin
        wait_trn(1, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        abort = 1'b1;
        exp_beats.delete();
        #1;
        check("mid_rst_src_rdy", 80'(trn_tsrc_rdy_n), 80'(1));
        check("mid_rst_trem", 80'(trn_trem_n), 80'(8'hFF));
        check("mid_rst_my_trn", 80'(my_trn), 80'(0));
        check("mid_rst_arb_err", 80'(arb_err), 80'(0));
      end
    join
    abort = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_gnt.push_back(3'b100);
    send(2, 2, 11, 0);
    @(posedge clk);
    @(negedge clk);
    check("post_rst_drop", 80'(my_trn), 80'(0));
    check("beats_left", 80'(exp_beats.size()), 80'(0));
    check("grants_left", 80'(exp_gnt.size()), 80'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
